// File: rtl/axi_master_wrapper_if.sv
// ---------------------------------------------------------------------------
// axi_master_wrapper_if
// Groups all the signals of axi_master_wrapper apart from clock and reset.
// This covers the core-side request/stream signals and one AXI4 master port.
//   modport master : the wrapper's view. It drives req_ready, the core read
//                    stream, done/err and the AXI master outputs.
//   modport slave  : the environment's view. It is the core plus the AXI
//                    slave, and it drives everything the wrapper samples.
// Signal groups:
//   req_*               request handshake (valid/ready, write, addr, len)
//   core_w* / core_r*   write and read beat streams to/from the core
//   done, err           completion pulse and error status
//   aw*/w*/b*/ar*/r*    AXI4 channels
// ---------------------------------------------------------------------------
interface axi_master_wrapper_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);
  localparam int STRB_W = DATA_W / 8;

  // Core side
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] core_wdata;
  logic [STRB_W-1:0] core_wstrb;
  logic              core_wvalid;
  logic              core_wready;
  logic [DATA_W-1:0] core_rdata;
  logic              core_rvalid;
  logic              core_rready;
  logic              core_rlast;
  logic              done;
  logic              err;

  // AXI write address / data / response
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [LEN_W-1:0]  awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  // AXI read address / data
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    input  req_valid, req_write, req_addr, req_len,
    input  core_wdata, core_wstrb, core_wvalid, core_rready,
    output req_ready, core_wready, core_rdata, core_rvalid, core_rlast, done, err,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len,
    output core_wdata, core_wstrb, core_wvalid, core_rready,
    input  req_ready, core_wready, core_rdata, core_rvalid, core_rlast, done, err,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_master_wrapper.sv
// ---------------------------------------------------------------------------
// axi_master_wrapper
// Bridges a simple core request/stream interface to one AXI4 master port.
// It runs one INCR burst (read or write) at a time. At the end of each
// burst it pulses done for one cycle, and err is valid alongside done.
// Ports:
//   aclk      clock
//   areset_n  synchronous, active-low reset
//   bus       axi_master_wrapper_if.master (core side plus AXI master channels)
// ---------------------------------------------------------------------------
module axi_master_wrapper #(
  parameter int              ID_W   = 4,
  parameter int              ADDR_W = 32,
  parameter int              DATA_W = 32,
  parameter int              LEN_W  = 8,
  parameter logic [ID_W-1:0] MST_ID = ID_W'(1)
) (
  input  logic                   aclk,
  input  logic                   areset_n,
  axi_master_wrapper_if.master   bus
);

  localparam int         STRB_W = DATA_W / 8;
  localparam logic [2:0] AXSIZE = 3'($clog2(STRB_W));
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_err;       // error accumulator for the current burst
  logic              r_done;
  logic              r_err_out;

  logic w_req_ready;
  logic w_req_hs;
  logic w_r_hs;
  logic w_w_hs;
  logic w_last;
  logic w_r_beat_err;
  logic w_b_err;

  // done is high in the first IDLE cycle after a burst. Holding req_ready low
  // for that cycle means a back-to-back request is taken one cycle later.
  assign w_req_ready  = (r_state == S_IDLE) && !r_done;
  assign w_req_hs     = w_req_ready && bus.req_valid;
  assign w_r_hs       = (r_state == S_R) && bus.rvalid && bus.core_rready;
  assign w_w_hs       = (r_state == S_W) && bus.core_wvalid && bus.wready;
  assign w_last       = (r_cnt == r_len);
  // A beat is bad if:
  //   - the response is not OKAY,
  //   - the ID is foreign,
  //   - or the slave's rlast disagrees with our own beat count.
  assign w_r_beat_err = (bus.rresp != RESP_OKAY) || (bus.rid != MST_ID) ||
                        (bus.rlast != w_last);
  assign w_b_err      = (bus.bresp != RESP_OKAY) || (bus.bid != MST_ID);

  // State register
  // NOTE: every clocked process uses non-blocking assignments, so all
  // registers update together from the values sampled before the edge.
  always_ff @(posedge aclk) begin
    if (!areset_n) r_state <= S_IDLE;
    else           r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    // NOTE: each combinational output gets a default before the case.
    // That way no path can leave it unassigned and infer a latch.
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_req_hs)                 w_next_state = bus.req_write ? S_AW : S_AR;
      S_AR:   if (bus.arready)              w_next_state = S_R;
      S_R:    if (w_r_hs && bus.rlast)      w_next_state = S_IDLE;
      S_AW:   if (bus.awready)              w_next_state = S_W;
      S_W:    if (w_w_hs && w_last)         w_next_state = S_B;
      S_B:    if (bus.bvalid)               w_next_state = S_IDLE;
      default:                              w_next_state = S_IDLE;
    endcase
  end

  // Burst context, beat counter, error accumulator and the done/err pulse
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
      r_err_out <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_err_out <= 1'b0;
      if (w_req_hs) begin
        r_addr <= bus.req_addr;
        r_len  <= bus.req_len;
        r_cnt  <= '0;
        r_err  <= 1'b0;
      end
      if (w_r_hs) begin
        r_cnt <= r_cnt + LEN_W'(1);
        r_err <= r_err | w_r_beat_err;
        if (bus.rlast) begin
          r_done    <= 1'b1;
          r_err_out <= r_err | w_r_beat_err;
        end
      end
      // Only wraps after the final beat of a 2**LEN_W-beat burst. By then
      // the FSM has already left W, so the wrapped value is never used.
      if (w_w_hs) r_cnt <= r_cnt + LEN_W'(1);
      if ((r_state == S_B) && bus.bvalid) begin
        r_done    <= 1'b1;
        r_err_out <= r_err | w_b_err;
      end
    end
  end

  // Output logic.
  // Handshake outputs are also gated by areset_n. This forces them low
  // while reset is held, even in the cycle before the state register
  // returns to IDLE.
  always_comb begin
    bus.req_ready   = w_req_ready && areset_n;
    bus.done        = r_done;
    bus.err         = r_err_out;

    bus.arid        = MST_ID;
    bus.araddr      = r_addr;
    bus.arlen       = r_len;
    bus.arsize      = AXSIZE;
    bus.arburst     = BURST_INCR;
    bus.arvalid     = (r_state == S_AR) && areset_n;

    bus.rready      = (r_state == S_R) && bus.core_rready && areset_n;
    bus.core_rvalid = (r_state == S_R) && bus.rvalid && areset_n;
    bus.core_rdata  = bus.rdata;
    bus.core_rlast  = bus.rlast;

    bus.awid        = MST_ID;
    bus.awaddr      = r_addr;
    bus.awlen       = r_len;
    bus.awsize      = AXSIZE;
    bus.awburst     = BURST_INCR;
    bus.awvalid     = (r_state == S_AW) && areset_n;

    bus.wvalid      = (r_state == S_W) && bus.core_wvalid && areset_n;
    bus.core_wready = (r_state == S_W) && bus.wready && areset_n;
    bus.wdata       = bus.core_wdata;
    bus.wstrb       = bus.core_wstrb;
    bus.wlast       = (r_state == S_W) && w_last;

    bus.bready      = (r_state == S_B) && areset_n;
  end

endmodule

// File: tb/tb_axi_master_wrapper.sv
// ---------------------------------------------------------------------------
// tb_axi_master_wrapper
// Directed bench for axi_master_wrapper. The stimulus tasks play both the
// core and the AXI slave. For every transaction they push the expected
// address phase, data beats and completion status into queues. A monitor
// samples on the falling edge and pops/compares whenever the DUT shows a
// handshake or a done pulse.
// ---------------------------------------------------------------------------
module tb_axi_master_wrapper;

  localparam int         ID_W   = 4;
  localparam int         ADDR_W = 32;
  localparam int         DATA_W = 32;
  localparam int         LEN_W  = 8;
  localparam logic [3:0] MST_ID = 4'h1;

  logic aclk = 1'b0;
  logic areset_n = 1'b0;
  always #5 aclk = ~aclk;

  axi_master_wrapper_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  axi_master_wrapper #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MST_ID(MST_ID)
  ) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .bus      (bus)
  );

  typedef struct { logic wr; logic [31:0] addr; logic [7:0] len; } addr_exp_t;
  typedef struct { logic [31:0] data; logic last; } rd_exp_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } wb_exp_t;

  addr_exp_t q_addr[$];
  rd_exp_t   q_rd[$];
  wb_exp_t   q_wb[$];
  logic      q_done[$];

  logic [31:0] wdat [256];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge aclk) begin
    addr_exp_t ea;
    rd_exp_t   er;
    wb_exp_t   ew;
    logic      ee;
    if (areset_n) begin
      if (bus.arvalid && bus.arready) begin
        check("ar_pending", 64'(q_addr.size() > 0), 1);
        if (q_addr.size() > 0) begin
          ea = q_addr.pop_front();
          check("ar_is_read", 64'(ea.wr), 0);
          check("ar_addr", bus.araddr, ea.addr);
          check("ar_len", bus.arlen, ea.len);
          check("ar_size", bus.arsize, 3'b010);
          check("ar_burst", bus.arburst, 2'b01);
          check("ar_id", bus.arid, MST_ID);
        end
      end
      if (bus.awvalid && bus.awready) begin
        check("aw_pending", 64'(q_addr.size() > 0), 1);
        if (q_addr.size() > 0) begin
          ea = q_addr.pop_front();
          check("aw_is_write", 64'(ea.wr), 1);
          check("aw_addr", bus.awaddr, ea.addr);
          check("aw_len", bus.awlen, ea.len);
          check("aw_size", bus.awsize, 3'b010);
          check("aw_burst", bus.awburst, 2'b01);
          check("aw_id", bus.awid, MST_ID);
        end
      end
      if (bus.core_rvalid && bus.core_rready) begin
        check("r_beat_pending", 64'(q_rd.size() > 0), 1);
        if (q_rd.size() > 0) begin
          er = q_rd.pop_front();
          check("core_rdata", bus.core_rdata, er.data);
          check("core_rlast", bus.core_rlast, er.last);
          check("rready_on_beat", bus.rready, 1);
        end
      end
      if (bus.wvalid && bus.wready) begin
        check("w_beat_pending", 64'(q_wb.size() > 0), 1);
        if (q_wb.size() > 0) begin
          ew = q_wb.pop_front();
          check("wdata", bus.wdata, ew.data);
          check("wstrb", bus.wstrb, ew.strb);
          check("wlast", bus.wlast, ew.last);
          check("core_wready", bus.core_wready, 1);
        end
      end
      if (bus.done) begin
        check("done_pending", 64'(q_done.size() > 0), 1);
        check("req_ready_during_done", bus.req_ready, 0);
        if (q_done.size() > 0) begin
          ee = q_done.pop_front();
          check("done_err", bus.err, ee);
        end
      end else if (bus.err) begin
        check("err_without_done", bus.err, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue_req(input logic wr, input logic [31:0] addr, input logic [7:0] len);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_len   = len;
    #1;
    for (int i = 0; i < 20 && !bus.req_ready; i++) tick();
    check("req_accepted", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                         input int n_beats, input bit toggle, input logic exp_err);
    logic phase;
    logic hs;
    logic [31:0] d;
    phase = 1'b1;
    q_addr.push_back('{1'b0, addr, len});
    q_done.push_back(exp_err);
    issue_req(1'b0, addr, len);
    for (int i = 0; i < 20 && !bus.arvalid; i++) tick();
    check("arvalid_seen", bus.arvalid, 1);
    check("no_rready_in_ar", bus.rready, 0);
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    for (int b = 0; b < n_beats; b++) begin
      d = addr ^ (32'(b) * 32'h0101_0101) ^ 32'h5A00_0000;
      q_rd.push_back('{d, (b == n_beats - 1)});
      bus.rvalid = 1'b1;
      bus.rdata  = d;
      bus.rlast  = (b == n_beats - 1);
      bus.rresp  = 2'b00;
      bus.rid    = MST_ID;
      hs = 1'b0;
      for (int c = 0; c < 20 && !hs; c++) begin
        bus.core_rready = toggle ? phase : 1'b1;
        phase = ~phase;
        #1;
        if (toggle) begin
          check("rready_mirror", bus.rready, bus.core_rready);
          check("rdata_stable", bus.core_rdata, d);
        end
        hs = bus.core_rvalid && bus.core_rready;
        tick();
      end
      check("r_beat_taken", hs, 1);
    end
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.core_rready = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] strb,
                          input logic [1:0] bresp, input logic exp_err,
                          input int aw_delay, input int reset_beat);
    logic aborted;
    aborted = 1'b0;
    q_addr.push_back('{1'b1, addr, len});
    if (reset_beat < 0) q_done.push_back(exp_err);
    issue_req(1'b1, addr, len);
    bus.core_wvalid = 1'b1;
    bus.core_wdata  = wdat[0];
    bus.core_wstrb  = strb;
    for (int i = 0; i < 20 && !bus.awvalid; i++) tick();
    check("awvalid_seen", bus.awvalid, 1);
    for (int i = 0; i < aw_delay; i++) begin
      #1;
      check("no_w_before_aw", bus.wvalid, 0);
      check("awaddr_stable", bus.awaddr, addr);
      tick();
    end
    bus.awready = 1'b1;
    tick();
    bus.awready = 1'b0;
    bus.wready  = 1'b1;
    for (int b = 0; b <= int'(len) && !aborted; b++) begin
      bus.core_wdata = wdat[b];
      if (b == reset_beat) begin
        areset_n = 1'b0;
        tick();
        areset_n = 1'b1;
        bus.core_wvalid = 1'b0;
        bus.wready = 1'b0;
        #1;
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_wvalid", bus.wvalid, 0);
        check("rst_done", bus.done, 0);
        aborted = 1'b1;
      end else begin
        q_wb.push_back('{wdat[b], strb, (b == int'(len))});
        #1;
        check("w_beat_valid", bus.wvalid, 1);
        tick();
      end
    end
    bus.core_wvalid = 1'b0;
    bus.wready = 1'b0;
    if (!aborted) begin
      bus.bvalid = 1'b1;
      bus.bresp  = bresp;
      bus.bid    = MST_ID;
      #1;
      for (int i = 0; i < 20 && !bus.bready; i++) tick();
      check("bready", bus.bready, 1);
      tick();
      bus.bvalid = 1'b0;
      bus.bresp  = 2'b00;
    end
    repeat (4) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_len = '0;
    bus.core_wdata = '0; bus.core_wstrb = '0; bus.core_wvalid = 1'b0; bus.core_rready = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
    bus.bid = MST_ID; bus.bresp = 2'b00; bus.bvalid = 1'b0;
    bus.rid = MST_ID; bus.rdata = '0; bus.rresp = 2'b00; bus.rlast = 1'b0; bus.rvalid = 1'b0;

    areset_n = 1'b0;
    repeat (3) tick();
    check("reset_req_ready", bus.req_ready, 0);
    check("reset_done", bus.done, 0);
    check("reset_err", bus.err, 0);
    check("reset_arvalid", bus.arvalid, 0);
    check("reset_awvalid", bus.awvalid, 0);
    check("reset_wvalid", bus.wvalid, 0);
    check("reset_araddr", bus.araddr, 0);
    areset_n = 1'b1;
    #1;
    check("idle_req_ready", bus.req_ready, 1);
    tick();

    // Basic read, then an immediate back-to-back write
    do_read(32'h0000_1000, 8'd3, 4, 1'b0, 1'b0);

    wdat[0] = 32'hAAAA_5555;
    wdat[1] = 32'h1234_5678;
    do_write(32'h0000_2000, 8'd1, 4'hF, 2'b00, 1'b0, 3, -1);

    // core_rready toggling
    do_read(32'h0000_1100, 8'd3, 4, 1'b1, 1'b0);

    // SLVERR write response
    for (int i = 0; i < 256; i++) wdat[i] = 32'h3000_0000 + 32'(i) * 32'h11;
    do_write(32'h0000_2100, 8'd2, 4'hF, 2'b10, 1'b1, 0, -1);

    // Early rlast on beat 1 of a 4-beat burst
    do_read(32'h0000_1200, 8'd3, 2, 1'b0, 1'b1);

    // Single-beat read
    do_read(32'h0000_1300, 8'd0, 1, 1'b0, 1'b0);

    // Maximum-length write, partial strobes
    for (int i = 0; i < 256; i++) wdat[i] = 32'hC000_0000 ^ (32'(i) << 8) ^ 32'(i);
    do_write(32'h0000_4000, 8'd255, 4'h3, 2'b00, 1'b0, 1, -1);

    // Reset during W beat 2 of an 8-beat write
    for (int i = 0; i < 256; i++) wdat[i] = 32'h7700_0000 + 32'(i);
    do_write(32'h0000_5000, 8'd7, 4'hF, 2'b00, 1'b0, 0, 2);

    // Recovery after the mid-burst reset
    do_read(32'h0000_6000, 8'd1, 2, 1'b0, 1'b0);

    repeat (5) tick();
    check("q_addr_drained", 64'(q_addr.size()), 0);
    check("q_rd_drained", 64'(q_rd.size()), 0);
    check("q_wb_drained", 64'(q_wb.size()), 0);
    check("q_done_drained", 64'(q_done.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
